// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad column scanner, frame decoder and debouncer.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes on key_pulse for held keys.
module keypad_scan #(
    parameter int CLK_DIV       = 25000,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_pulse
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE);

    if (CLK_DIV < 2 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_scan: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_state_e;

    // Code of the single pressed key; ghosting or multi-press yields 0.
    function automatic logic [3:0] frame_code(input logic [11:0] keys);
        logic [3:0] hits;
        logic [3:0] code;
        hits = 4'd0;
        code = 4'd0;
        for (int i = 0; i < 12; i++) begin
            hits = hits + {3'd0, keys[i]};
            code = keys[i] ? 4'(i + 1) : code;
        end
        return (hits == 4'd1) ? code : 4'd0;
    endfunction

    function automatic logic [2:0] col_drive(input col_state_e col);
        logic [2:0] drive;
        case (col)
            COL0:    drive = 3'b110;
            COL1:    drive = 3'b101;
            COL2:    drive = 3'b011;
            default: drive = 3'b110;
        endcase
        return drive;
    endfunction

    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    col_state_e       col_state_r;
    col_state_e       col_next_s;
    logic [2:0]       key_col_r;
    logic [3:0]       samp0_r;
    logic [3:0]       samp1_r;
    logic [3:0]       samp2_r;
    logic             eval_r;
    logic [11:0]      keys_s;
    logic [3:0]       code_s;
    logic [3:0]       cand_r;
    logic [3:0]       stab_r;
    logic [3:0]       cand_next_s;
    logic [3:0]       stab_next_s;
    logic             accept_s;
    logic [3:0]       key_data_r;
    logic             key_valid_r;
    logic             key_pulse_r;
    logic             rpt_fire_s;

    // Two-flop synchroniser for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= key_row;
            row_sync_r <= row_meta_r;
        end
    end

    // Scan tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    assign tick_s = (div_r == DIV_LAST);

    // Column state register and column drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_state_r <= COL0;
            key_col_r   <= 3'b110;
        end else begin
            col_state_r <= col_next_s;
            key_col_r   <= col_drive(col_next_s);
        end
    end

    // Column sequencing: advance one column per tick.
    always_comb begin
        col_next_s = col_state_r;
        if (tick_s) begin
            case (col_state_r)
                COL0:    col_next_s = COL1;
                COL1:    col_next_s = COL2;
                COL2:    col_next_s = COL0;
                default: col_next_s = COL0;
            endcase
        end else begin
            col_next_s = col_state_r;
        end
    end

    // Capture the active-high rows for the column currently driven; flag frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp0_r <= 4'd0;
            samp1_r <= 4'd0;
            samp2_r <= 4'd0;
            eval_r  <= 1'b0;
        end else begin
            eval_r <= tick_s && (col_state_r == COL2);
            if (tick_s) begin
                case (col_state_r)
                    COL0:    samp0_r <= ~row_sync_r;
                    COL1:    samp1_r <= ~row_sync_r;
                    COL2:    samp2_r <= ~row_sync_r;
                    default: samp0_r <= samp0_r;
                endcase
            end else begin
                samp0_r <= samp0_r;
            end
        end
    end

    // Flatten samples so bit r*3+c is the key at row r / column c.
    always_comb begin
        keys_s = 12'd0;
        for (int r = 0; r < 4; r++) begin
            keys_s[r*3 + 0] = samp0_r[r];
            keys_s[r*3 + 1] = samp1_r[r];
            keys_s[r*3 + 2] = samp2_r[r];
        end
    end

    // Debounce: count identical frames, accept once the streak reaches DEBOUNCE.
    always_comb begin
        code_s      = frame_code(keys_s);
        cand_next_s = cand_r;
        stab_next_s = stab_r;
        if (code_s == cand_r) begin
            stab_next_s = (stab_r >= DEB_MAX) ? DEB_MAX : stab_r + 4'd1;
        end else begin
            cand_next_s = code_s;
            stab_next_s = 4'd1;
        end
        accept_s = eval_r && (stab_next_s == DEB_MAX) && (cand_next_s != key_data_r);
    end

    // Debouncer state, updated once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= 4'd0;
            stab_r <= 4'd0;
        end else if (eval_r) begin
            cand_r <= cand_next_s;
            stab_r <= stab_next_s;
        end else begin
            cand_r <= cand_r;
            stab_r <= stab_r;
        end
    end

    // Registered key outputs; a pulse marks every accepted nonzero code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_data_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_pulse_r <= 1'b0;
        end else begin
            if (accept_s) begin
                key_data_r  <= cand_next_s;
                key_valid_r <= (cand_next_s != 4'd0);
            end else begin
                key_data_r  <= key_data_r;
                key_valid_r <= key_valid_r;
            end
            key_pulse_r <= (accept_s && (cand_next_s != 4'd0)) || rpt_fire_s;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int             RPT_W    = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRAMES - 1);

    logic [RPT_W-1:0] rpt_cnt_r;
    logic [RPT_W-1:0] rpt_next_s;

    // Repeat counter: frames since the held code was accepted or last repeated.
    always_comb begin
        rpt_next_s = rpt_cnt_r;
        rpt_fire_s = 1'b0;
        if (accept_s) begin
            rpt_next_s = '0;
        end else if (eval_r && (key_data_r != 4'd0)) begin
            if (rpt_cnt_r == RPT_LAST) begin
                rpt_next_s = '0;
                rpt_fire_s = 1'b1;
            end else begin
                rpt_next_s = rpt_cnt_r + RPT_W'(1);
            end
        end else begin
            rpt_next_s = rpt_cnt_r;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_r <= '0;
        end else begin
            rpt_cnt_r <= rpt_next_s;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    assign key_col   = key_col_r;
    assign key_data  = key_data_r;
    assign key_valid = key_valid_r;
    assign key_pulse = key_pulse_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: directed test-plan steps plus random key
// frames, compared against a frame-level reference model of the debounce rules.
module tb_keypad_scan;

    localparam int CLK_DIV       = 4;
    localparam int DEBOUNCE      = 3;
    localparam int REPEAT_FRAMES = 5;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_pulse;

    logic [11:0] pressed_keys;

    int checks;
    int errors;

    logic [3:0] m_hist[$];
    logic [3:0] m_data;
    int         m_since;

    keypad_scan #(
        .CLK_DIV      (CLK_DIV),
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_FRAMES(REPEAT_FRAMES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_data (key_data),
        .key_valid(key_valid),
        .key_pulse(key_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed_keys[r*3 + c] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_code(input logic [11:0] keys);
        if ($countones(keys) != 1) return 4'd0;
        for (int i = 0; i < 12; i++)
            if (keys[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    // Reference: accept a code once the last DEBOUNCE frames all show it and it differs.
    task automatic model_frame(input logic [11:0] keys, output logic exp_pulse);
        logic [3:0] code;
        logic       steady;
        code = ref_code(keys);
        m_hist.push_back(code);
        if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
        steady = (m_hist.size() == DEBOUNCE);
        foreach (m_hist[i])
            if (m_hist[i] != code) steady = 1'b0;
        exp_pulse = 1'b0;
        if (steady && code != m_data) begin
            m_data    = code;
            exp_pulse = (code != 4'd0);
            m_since   = 0;
        end else if (m_data != 4'd0) begin
            m_since++;
`ifdef KEYPAD_REPEAT_EN
            if (m_since % REPEAT_FRAMES == 0) exp_pulse = 1'b1;
`endif
        end
    endtask

    // One frame: hold keys, check column drive each clk, then the frame's outputs.
    task automatic step_frame(input logic [11:0] keys);
        logic       exp_pulse;
        logic [2:0] exp_col;
        int         pulses;
        pressed_keys = keys;
        pulses = 0;
        model_frame(keys, exp_pulse);
        for (int j = 1; j <= 3 * CLK_DIV; j++) begin
            @(posedge clk);
            #1;
            exp_col = (j < 3) ? 3'b110 : (j < 7) ? 3'b101 : (j < 11) ? 3'b011 : 3'b110;
            check("key_col", {29'd0, key_col}, {29'd0, exp_col});
            if (key_pulse) pulses++;
        end
        check("key_data", {28'd0, key_data}, {28'd0, m_data});
        check("key_valid", {31'd0, key_valid}, {31'd0, (m_data != 4'd0)});
        check("key_pulse_count", pulses, {31'd0, exp_pulse});
    endtask

    task automatic hold(input logic [11:0] keys, input int frames);
        for (int f = 0; f < frames; f++) step_frame(keys);
    endtask

    task automatic do_reset(input int wait_cycles);
        repeat (wait_cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        pressed_keys = 12'd0;
        #1;
        check("rst_key_col", {29'd0, key_col}, 32'h6);
        check("rst_key_data", {28'd0, key_data}, 32'h0);
        check("rst_key_valid", {31'd0, key_valid}, 32'h0);
        check("rst_key_pulse", {31'd0, key_pulse}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hist.delete();
        m_data  = 4'd0;
        m_since = 0;
        @(posedge clk);
        #1;
        check("post_rst_key_col", {29'd0, key_col}, 32'h6);
    endtask

    initial begin
        logic [11:0] keys;
        int          sel;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        pressed_keys = 12'd0;
        m_data       = 4'd0;
        m_since      = 0;

        do_reset(3);
        hold(12'd0, 2);

        // Single press of key 1 and release.
        hold(12'h001, 5);
        hold(12'd0, 4);

        // Bounce on code 8, then steady.
        for (int f = 0; f < 10; f++) step_frame((f % 2 == 0) ? 12'h080 : 12'h000);
        hold(12'h080, 4);
        hold(12'd0, 4);

        // Codes 5 and 9 together, then 9 released.
        hold(12'h110, 4);
        hold(12'h010, 4);
        hold(12'd0, 4);

        // Direct change from '#' to '*'.
        hold(12'h800, 4);
        hold(12'h200, 4);
        hold(12'd0, 4);

        // Reset in the middle of a frame while a key is held.
        hold(12'h004, 2);
        do_reset(5);
        hold(12'h004, 4);

        // Long hold of key 1 (repeat strobes when enabled).
        hold(12'h001, 17);
        hold(12'd0, 4);

        // Random frames: mostly held, some releases, singles and multi-presses.
        keys = 12'd0;
        for (int f = 0; f < 60; f++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      keys = keys;
            else if (sel < 7) keys = 12'd0;
            else if (sel < 9) keys = 12'd1 << $urandom_range(0, 11);
            else              keys = (12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11));
            step_frame(keys);
        end
        hold(12'd0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad scanner and debouncer for the 4-row x 3-column front-panel keypad; it drives the column lines, samples the rows and produces the debounced key code consumed by the menu and game state blocks. It sits directly upstream of the main-menu stage, which acts on `key_data`, for example leaving the menu when `key_data == 1`. It also provides a one-clock press strobe so game logic can count presses without edge detection of its own.

## Interface
- `CLK_DIV`, default 25000: clk cycles per scan tick, giving 1 ms at 25 MHz; legal range ≥ 2.
- `DEBOUNCE`, default 4: consecutive identical frames required to accept a new code; legal range 1..15.
- `REPEAT_FRAMES`, default 100: frames between repeat strobes. Used only with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_row`  in  4  raw row lines, active-low (pulled up), asynchronous to `clk`.
- `key_col`  out  3  column drive, active-low, exactly one bit low at all times.
- `key_data`  out  4  debounced key code; 0 = no key.
- `key_valid`  out  1  high while `key_data != 0`.
- `key_pulse`  out  1  one-clk strobe on each accepted press.

## Operation
- **Row synchronisation:** `key_row` passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- **Tick generation:** a divider counts from 0 to `CLK_DIV-1`, then wraps. The tick is asserted for one clk when the divider equals `CLK_DIV-1`.
- **On each tick:**
  - Store the inverted synchronised rows for the current column `c`.
  - Advance `c` through 0→1→2→0.
  - Drive `key_col` as `~(1<<c)`.
- **Frame:** a frame is the three ticks for c = 0, 1, 2. Frame evaluation happens on the clk edge after the c = 2 sample.
- **Key code:** row r (0..3) and column c give code r*3+c+1. Keys 1–9 map to codes 1–9; `*` = 10, `0` = 11, `#` = 12.
- **Frame code:**
  - No key pressed → 0.
  - Exactly one key pressed → that key's code.
  - Two or more keys pressed (ghost or multi-press) → 0.
- **Debounce:** the debouncer holds `cand` (4 bits) and `stab` (4 bits).
  - If the frame code equals `cand`, `stab` saturates at `DEBOUNCE`.
  - Otherwise `cand` takes the frame code and `stab` is set to 1.
  - When `stab` reaches `DEBOUNCE` and `cand != key_data`, load `key_data <= cand`.
- **`key_pulse`:** asserted on the same edge that `key_data` loads a nonzero value. This includes a direct change between two nonzero codes (A→B), with no 0 in between.
- **Release:** the release path uses the same rule. `key_data` returns to 0 after `DEBOUNCE` zero frames, and no pulse is generated.
- **Codes 13–15:** never produced.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n` low):
  - `key_col` = 3'b110
  - `key_data` = 0, `key_valid` = 0, `key_pulse` = 0
  - divider, `c`, `cand`, `stab` and the repeat counter = 0
  - synchroniser flops = 4'b1111
- **Reset mid-frame:** partial column samples are discarded. The scan restarts at c = 0 after `rst_n` rises, and the first tick occurs `CLK_DIV` clks later.
- **Column settle:** each column is driven for one full tick period before it is sampled.
- **Press latency:** for a key that is stable from before a frame start, `key_data` updates (`DEBOUNCE` frames) x (3 x `CLK_DIV`) + 1 clk after that frame starts. The synchroniser adds up to 2 clks.
- **`key_valid`** is registered alongside `key_data` and changes on the same edge.
- **`key_pulse`** is exactly one clk wide and never asserted in two consecutive cycles.
- **Bounce:** a key bouncing within a single frame is seen only through that frame's samples. A code change resets `stab` to 1, so nothing is accepted early.

## Configuration
- **`KEYPAD_REPEAT_EN` defined:**
  - While `key_data` is nonzero and unchanged, a frame counter runs.
  - After `REPEAT_FRAMES` further frames, `key_pulse` fires again, and then again every `REPEAT_FRAMES` frames.
  - The counter clears on any `key_data` change or reset.
- **`KEYPAD_REPEAT_EN` undefined:** no repeat logic. `key_pulse` fires only on accepted presses, as described in Operation.

## Test plan
Unless stated otherwise, benches use `CLK_DIV` = 4, `DEBOUNCE` = 3, `REPEAT_FRAMES` = 5.

1. **Reset:** drive `rst_n` low mid-scan → `key_col` = 3'b110 and `key_data` = 0 immediately. After release, first tick at clk 4; `key_col` cycles 110→101→011 every 4 clks.
2. **Single press:** hold the key at row 0 / col 0, i.e. row 0 low while `key_col[0]` is low → `key_data` = 1 after 3 frames (36 clks + 1 clk + sync). `key_valid` = 1 and one `key_pulse`. Release → `key_data` = 0 after 3 zero frames, with no pulse.
3. **Bounce rejection:** toggle row 2 / col 1 (code 8) every frame for 10 frames → `key_data` stays 0 and `key_pulse` never asserts. Then hold the key → `key_data` = 8 after 3 stable frames.
4. **Multi-press:** press codes 5 and 9 together → `key_data` stays 0. Release 9 → `key_data` = 5 with one pulse.
5. **Direct change:** hold `#` (row 3 / col 2), giving `key_data` = 12. Switch directly to `*` (row 3 / col 0) → `key_data` goes 12→10 with a single pulse, never passing through 0.
6. **Repeat** (`KEYPAD_REPEAT_EN`): hold key 1 → pulses at acceptance, then 5, 10 and 15 frames later. With the macro undefined → exactly one pulse.
